// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and FSM state type for the UART transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int SAMPLES_PER_BIT = 16;
  localparam int SAMPLE_W        = $clog2(SAMPLES_PER_BIT);

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Turns the running XOR of the data bits into the bit actually sent.
  function automatic logic parity_bit(input logic acc, input int mode);
    return (mode == PAR_ODD) ? ~acc : acc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_bit_timer.sv
// ============================================================================
// Module      : tx_bit_timer
// Description : Free-running 16-sample slot timer; held at zero while disabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_bit_timer
  import uart_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  output logic [SAMPLE_W-1:0] count,
  output logic                lastSample
);

  logic [SAMPLE_W-1:0] count_q;
  logic [SAMPLE_W-1:0] count_d;

  // Wraps 15 -> 0 naturally, so every slot after the first also starts at zero.
  always_comb begin
    count_d = count_q + SAMPLE_W'(1);
    if (!enable) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign lastSample = (count_q == SAMPLE_W'(SAMPLES_PER_BIT - 1));

endmodule

`default_nettype wire

// File: rtl/uart_tx_framer.sv
// ============================================================================
// Module      : uart_tx_framer
// Description : UART frame serialiser (start, LSB-first data, parity, stop).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] txData,
  input  logic                 load,
  output logic                 ready,
  output logic                 txOut,
  output logic                 done
);

  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;

  logic                 timer_en;
  logic [SAMPLE_W-1:0]  sample_cnt;
  logic                 slot_end;
  logic                 unused_sample_cnt;

  assign timer_en          = (state_q != ST_IDLE);
  assign unused_sample_cnt = ^sample_cnt;

  tx_bit_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .enable     (timer_en),
    .count      (sample_cnt),
    .lastSample (slot_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    parity_d  = parity_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d   = ST_START;
          shift_d   = txData;
          bit_idx_d = '0;
          parity_d  = 1'b0;
        end
      end
      ST_START: begin
        if (slot_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (slot_end) begin
          parity_d = parity_q ^ shift_q[0];
          shift_d  = shift_q >> 1;
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (slot_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (slot_end) begin
          if (bit_idx_q == LAST_STOP) begin
            bit_idx_d = '0;
            state_d   = ST_IDLE;
            done_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The line is registered from the next state so it changes with the slot.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_bit(parity_d, PARITY);
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign txOut = tx_q;
  assign done  = done_q;

endmodule

`default_nettype wire

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter DATA_BITS, default 8: payload width in bits; legal values 5-8.
REQ-002 Parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-003 Parameter STOP_BITS, default 1: number of stop bits; legal values 1 or 2.
REQ-004 Port clk, input, 1: 16x baud-rate clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port txData, input, DATA_BITS: byte to transmit; sampled only on the accepting edge.
REQ-007 Port load, input, 1: transmit request; acts as valid.
REQ-008 Port ready, output, 1: block is idle and can accept load.
REQ-009 Port txOut, output, 1: serial line, registered; idles high.
REQ-010 Port done, output, 1: one-cycle pulse marking frame completion.

Function
REQ-011 The block SHALL accept a frame on any rising edge where load=1 and ready=1, capturing txData into an internal shift register.
REQ-012 The block SHALL ignore load while ready=0; txData changes during a frame SHALL NOT affect the frame in flight.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; ready=1 only in IDLE.
REQ-014 Transitions: IDLE->START on accept; START->DATA after 16 clks; DATA->PARITY (PARITY!=0) or DATA->STOP after DATA_BITS bits; PARITY->STOP after 16 clks; STOP->IDLE after 16*STOP_BITS clks.
REQ-015 Each bit slot SHALL last exactly 16 clk cycles, timed by a 4-bit sample counter that clears on entry to each slot and wraps from 15 to 0.
REQ-016 The start bit SHALL be 0, data bits SHALL be sent LSB first, and stop bits SHALL be 1.
REQ-017 The parity bit SHALL make the total count of ones over data plus parity even (PARITY=1) or odd (PARITY=2).
REQ-018 txOut SHALL show the start bit starting in the cycle after the accepting edge (1-cycle latency).
REQ-019 The frame length SHALL be 16*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) clks; the default configuration gives 160.
REQ-020 done SHALL pulse for exactly one cycle, in the first IDLE cycle after the final stop slot, coincident with ready rising.
REQ-021 A load held high SHALL be accepted in that same done/ready cycle, giving exactly one idle-high clk between back-to-back frames.
REQ-022 In IDLE, txOut SHALL be 1 and the sample counter SHALL hold at 0.

Reset
REQ-023 On rst=1 at a rising edge, the block SHALL set state=IDLE, txOut=1, ready=1, done=0, sample counter=0, bit index=0 and shift register=0.
REQ-024 A reset mid-frame SHALL abandon the frame: txOut=1 from the next cycle, and done SHALL NOT pulse.
REQ-025 If rst and load are both 1 in the same cycle, reset SHALL win and no frame SHALL start.

Structure
REQ-026 Shared package uart_pkg SHALL hold SAMPLES_PER_BIT=16, the FSM state enumeration, and the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD).
REQ-027 The 16-sample slot timer SHALL be a sub-module tx_bit_timer (inputs enable, clk, rst; outputs count[3:0] and lastSample, where lastSample = count==15).
REQ-028 The parity bit SHALL be accumulated serially as bits shift out, not computed combinationally at load time.

Verification
REQ-029 Reset: hold rst=1 for 3 clks -> txOut=1, ready=1, done=0 on every cycle.
REQ-030 Default parameters, load 0xA5 -> txOut: 0 for 16 clks, then 1,0,1,0,0,1,0,1 (16 clks each), then 1 for 16; done=1 exactly 161 clks after the accepting edge.
REQ-031 PARITY=1, load 0x07 -> parity slot txOut=1; PARITY=2, load 0x07 -> parity slot txOut=0; frame is 176 clks.
REQ-032 load 0x3C, then pulse load with 0xFF at clk 40 -> 0xFF is ignored, frame bits match 0x3C, and ready stays 0 until done.
REQ-033 Assert rst during data bit 3 -> txOut=1 and ready=1 on the next cycle; done never pulses; a new load of 0x55 then transmits correctly.
REQ-034 STOP_BITS=2, load held high with 0x81 then 0x18 -> second start bit begins exactly 33 clks after the first stop slot begins, and done pulses twice.
